// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS core.
// Defining IF_FETCH_STALL_CNT_EN adds a saturating StallCount output.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        BranchTaken,
    input  logic [31:0] BranchAddr,
    input  logic        Jump,
    input  logic [31:0] JumpAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
`ifdef IF_FETCH_STALL_CNT_EN
    output logic [31:0] StallCount,
`endif
    output logic [31:0] PC,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid
);

    typedef enum logic [1:0] {
        stateFetch = 2'd0,
        stateHold  = 2'd1,
        stateDrop  = 2'd2
    } fetchState_t;

    fetchState_t state;
    fetchState_t nextState;
    logic [31:0] nextPc;
    logic [31:0] holdBuf;
    logic        captureHold;
    logic        redirect;
    logic [31:0] target;
    logic        avail;
    logic [31:0] fetchWord;
    logic [31:0] pcPlus4;

    assign redirect  = PCWrite & (Jump | BranchTaken);
    assign target    = Jump ? JumpAddr : BranchAddr;
    assign avail     = ((state == stateFetch) & imem_ready) | (state == stateHold);
    assign fetchWord = (state == stateHold) ? holdBuf : imem_rdata;
    assign pcPlus4   = PC + 32'd4;

    // Request is gated by reset so nothing issues until the cycle after deassertion.
    assign imem_req  = ~reset & (state != stateHold);
    assign imem_addr = PC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= stateFetch;
            PC      <= RESET_PC;
            holdBuf <= '0;
        end else begin
            state <= nextState;
            PC    <= nextPc;
            if (captureHold) begin
                holdBuf <= imem_rdata;
            end
        end
    end

    always_comb begin
        nextState   = state;
        nextPc      = PC;
        captureHold = 1'b0;
        case (state)
            stateFetch: begin
                if (redirect) begin
                    nextPc    = target;
                    nextState = imem_ready ? stateFetch : stateDrop;
                end else if (imem_ready) begin
                    if (IF_ID_Write & PCWrite) begin
                        nextPc = pcPlus4;
                    end else begin
                        nextState   = stateHold;
                        captureHold = 1'b1;
                    end
                end
            end
            stateHold: begin
                if (redirect) begin
                    nextPc    = target;
                    nextState = stateFetch;
                end else if (IF_ID_Write & PCWrite) begin
                    nextPc    = pcPlus4;
                    nextState = stateFetch;
                end
            end
            stateDrop: begin
                // The stale response cannot be cancelled; wait it out, tracking new targets.
                if (redirect) begin
                    nextPc = target;
                end
                if (imem_ready) begin
                    nextState = stateFetch;
                end
            end
            default: begin
                nextState = stateFetch;
            end
        endcase
    end

    // PC4 is left untouched on bubbles and squashes; only Instr and Valid mark them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_PC4   <= '0;
            IF_ID_Valid <= 1'b0;
        end else if (IF_ID_Write) begin
            if (redirect) begin
                IF_ID_Instr <= NOP_INSTR;
                IF_ID_Valid <= 1'b0;
            end else if (avail & PCWrite) begin
                IF_ID_Instr <= fetchWord;
                IF_ID_PC4   <= pcPlus4;
                IF_ID_Valid <= 1'b1;
            end else begin
                IF_ID_Instr <= NOP_INSTR;
                IF_ID_Valid <= 1'b0;
            end
        end
    end

`ifdef IF_FETCH_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCount <= '0;
        end else if ((~PCWrite | ~IF_ID_Write) && (StallCount != 32'hFFFF_FFFF)) begin
            StallCount <= StallCount + 32'd1;
        end
    end
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the five-stage MIPS core.
- Holds the PC and issues requests to a variable-latency instruction memory.
- Feeds the instruction and PC+4 into the ID stage and obeys the PCWrite/IF_ID_Write stall controls from the hazard detection unit.
- Redirects on taken branch or jump resolved in ID; the fetched wrong-path instruction is squashed.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, encoding written into IF/ID on bubble or flush (sll $0,$0,0).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- PCWrite  input  1  hazard unit: 0 = freeze PC and redirect.
- IF_ID_Write  input  1  hazard unit: 0 = hold the IF/ID register.
- BranchTaken  input  1  ID stage: branch condition true this cycle.
- BranchAddr  input  32  ID stage: branch target.
- Jump  input  1  ID stage: j/jal in ID this cycle.
- JumpAddr  input  32  ID stage: jump target.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address, word aligned.
- imem_rdata  input  32  fetched instruction, valid when imem_ready=1.
- imem_ready  input  1  one-cycle response strobe for the outstanding request.
- PC  output  32  current fetch PC.
- IF_ID_PC4  output  32  PC+4 of the instruction held in IF/ID.
- IF_ID_Instr  output  32  instruction held in IF/ID.
- IF_ID_Valid  output  1  1 = IF/ID holds a real instruction.

Behaviour:
- Reset (async): PC=RESET_PC, state=FETCH, IF_ID_Instr=NOP_INSTR, IF_ID_PC4=0, IF_ID_Valid=0, imem_req=0 during reset. The first request issues in the first cycle after reset deassertion.
- imem_addr=PC at all times. imem_req=1 in FETCH and DROP, 0 in HOLD. At most one request is outstanding. Memory responds 1..N cycles later and cannot cancel.
- redirect = PCWrite & (Jump | BranchTaken). target = JumpAddr if Jump, else BranchAddr (Jump has priority).
- "avail" is 1 if (state==FETCH & imem_ready) or state==HOLD. The available word comes from imem_rdata or the hold buffer.
- State transitions:
  - FETCH, redirect & no ready → DROP; PC<=target.
  - FETCH, redirect & ready → FETCH; PC<=target; data discarded.
  - FETCH, ready & IF_ID_Write & PCWrite → FETCH; PC<=PC+4.
  - FETCH, ready & (!IF_ID_Write | !PCWrite) → HOLD; imem_rdata captured into hold buffer.
  - HOLD, redirect → FETCH; PC<=target; buffer discarded.
  - HOLD, IF_ID_Write & PCWrite → FETCH; PC<=PC+4.
  - DROP, ready → FETCH; response discarded. The PC already equals target, so the refetch starts next cycle.
  - DROP, further redirect → PC<=new target; stays in DROP.
- IF/ID register update:
  - IF_ID_Write=0: hold all fields, including through a redirect.
  - Otherwise, if redirect: NOP_INSTR, Valid=0 (squash).
  - Otherwise, if avail & PCWrite: Instr=word, PC4=PC+4, Valid=1.
  - Otherwise: NOP_INSTR, Valid=0 (fetch bubble).
- PCWrite=0 blocks PC change and redirect. The branch stays in ID and is re-evaluated when the stall clears.
- PC+4 is modulo 2^32. No misalignment check is made.
- Reset mid-request: any later imem_ready before the new request is ignored, because the state after reset is FETCH with imem_req low during reset. The memory must drop in-flight responses on reset.

Optional Feature:
- Macro: IF_FETCH_STALL_CNT_EN.
- When defined, adds output StallCount[31:0]:
  - Reset to 0.
  - Increments by 1 each cycle where PCWrite=0 or IF_ID_Write=0.
  - Saturates at 32'hFFFF_FFFF.
- When undefined, the port and counter are absent. All other behaviour is identical.

Test Plan:
- Zero-wait memory, stall inputs high, no redirect, 4 cycles → PC 0,4,8,12. IF_ID_PC4 = 4,8,12 with Valid=1 from the cycle after each response.
- Response with IF_ID_Write=0 and PCWrite=0 for 3 cycles → state HOLD, imem_req=0, IF/ID unchanged, PC held. On release, the buffered word enters IF/ID and PC advances by 4.
- 3-cycle memory; BranchTaken=1, BranchAddr=0x40 on the first wait cycle → enters DROP, the returned word is never loaded (Valid=0). The next imem_addr=0x40 and its instruction reaches IF/ID with PC4=0x44.
- Jump=1 (JumpAddr=0x100) and BranchTaken=1 (BranchAddr=0x80) in the same cycle → PC=0x100, IF/ID squashed to NOP with Valid=0.
- BranchTaken=1 while PCWrite=0 → PC unchanged, no squash. The redirect takes effect the first cycle PCWrite=1.
- Assert reset while a request is outstanding → PC=RESET_PC immediately, Valid=0, imem_req=0 until reset deasserts. With the macro defined, StallCount=0.
